// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the flash pin-set arbiter.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWN_SPI  = 2'd1,
    OWN_QSPI = 2'd2,
    GUARD    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_SPI  = 1'b0,
    OWNER_QSPI = 1'b1
  } owner_t;

  // Legacy SPI drives MOSI, WP and HOLD; MISO stays an input.
  localparam logic [3:0] SPI_DOE = 4'b1101;

endpackage

// File: rtl/flash_bus_arbiter.sv
// Request/grant arbiter sharing the QSPI flash pads between the legacy SPI
// master and the QSPI controller, with a CS-high guard gap and idle preemption.
module flash_bus_arbiter
  import flash_arb_pkg::*;
#(
  parameter int GUARD_CYCLES = 4,
  parameter int HOLD_TIMEOUT = 1024,
  parameter int CNT_W        = 16
) (
  input  logic       iCLK,
  input  logic       iRESETn,
  input  logic       iSPI_REQ,
  output logic       oSPI_GNT,
  input  logic       iSPI_SCK,
  input  logic       iSPI_MOSI,
  input  logic       iSPI_CSn,
  output logic       oSPI_MISO,
  input  logic       iQSPI_REQ,
  output logic       oQSPI_GNT,
  input  logic       iQSPI_DCLK,
  input  logic       iQSPI_NCS,
  input  logic [3:0] iQSPI_DOUT,
  input  logic [3:0] iQSPI_DOE,
  output logic [3:0] oQSPI_DIN,
  output logic       oFLASH_SCK,
  output logic       oFLASH_CSn,
  output logic [3:0] oFLASH_DOUT,
  output logic [3:0] oFLASH_DOE,
  input  logic [3:0] iFLASH_DIN,
  output logic       oPREEMPT,
  output logic       oPROTO_ERR
);

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam bit               PREEMPT_EN = (HOLD_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST  = PREEMPT_EN ? CNT_W'(HOLD_TIMEOUT - 1) : '0;

  arb_state_t       r_state,     w_state_nxt;
  owner_t           r_last,      w_last_nxt;
  logic [CNT_W-1:0] r_guard_cnt, w_guard_nxt;
  logic [CNT_W-1:0] r_hold_cnt,  w_hold_nxt;
  logic             w_preempt,   w_proto_err;

  always_ff @(posedge iCLK) begin
    if (!iRESETn) begin
      r_state     <= GUARD;
      r_last      <= OWNER_QSPI;
      r_guard_cnt <= GUARD_LAST;
      r_hold_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_guard_cnt <= w_guard_nxt;
      r_hold_cnt  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_guard_nxt = r_guard_cnt;
    w_hold_nxt  = '0;
    w_preempt   = 1'b0;
    w_proto_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (iSPI_REQ && iQSPI_REQ) begin
          // Round robin: the master that did not own last goes first.
          if (r_last == OWNER_SPI) begin
            w_state_nxt = OWN_QSPI;
            w_last_nxt  = OWNER_QSPI;
          end else begin
            w_state_nxt = OWN_SPI;
            w_last_nxt  = OWNER_SPI;
          end
        end else if (iSPI_REQ) begin
          w_state_nxt = OWN_SPI;
          w_last_nxt  = OWNER_SPI;
        end else if (iQSPI_REQ) begin
          w_state_nxt = OWN_QSPI;
          w_last_nxt  = OWNER_QSPI;
        end
      end
      OWN_SPI: begin
        if (!iSPI_REQ) begin
          w_state_nxt = GUARD;
          w_guard_nxt = GUARD_LAST;
          w_proto_err = !iSPI_CSn;
        end else if (PREEMPT_EN && iQSPI_REQ && iSPI_CSn) begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_state_nxt = GUARD;
            w_guard_nxt = GUARD_LAST;
            w_preempt   = 1'b1;
          end else begin
            w_hold_nxt = r_hold_cnt + 1'b1;
          end
        end
      end
      OWN_QSPI: begin
        if (!iQSPI_REQ) begin
          w_state_nxt = GUARD;
          w_guard_nxt = GUARD_LAST;
          w_proto_err = !iQSPI_NCS;
        end else if (PREEMPT_EN && iSPI_REQ && iQSPI_NCS) begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_state_nxt = GUARD;
            w_guard_nxt = GUARD_LAST;
            w_preempt   = 1'b1;
          end else begin
            w_hold_nxt = r_hold_cnt + 1'b1;
          end
        end
      end
      default: begin
        if (r_guard_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_guard_nxt = r_guard_cnt - 1'b1;
        end
      end
    endcase
  end

  assign oSPI_GNT   = (r_state == OWN_SPI);
  assign oQSPI_GNT  = (r_state == OWN_QSPI);
  assign oPREEMPT   = w_preempt & iRESETn;
  assign oPROTO_ERR = w_proto_err & iRESETn;
  assign oSPI_MISO  = iFLASH_DIN[1];
  assign oQSPI_DIN  = iFLASH_DIN;

  // Pads follow the owner's pins with no latency; reset forces them idle at once.
  always_comb begin
    oFLASH_SCK  = 1'b0;
    oFLASH_CSn  = 1'b1;
    oFLASH_DOUT = 4'b0000;
    oFLASH_DOE  = 4'b0000;
    if (iRESETn && r_state == OWN_SPI) begin
      oFLASH_SCK  = iSPI_SCK;
      oFLASH_CSn  = iSPI_CSn;
      oFLASH_DOUT = {1'b1, 1'b1, 1'b0, iSPI_MOSI};
      oFLASH_DOE  = SPI_DOE;
    end else if (iRESETn && r_state == OWN_QSPI) begin
      oFLASH_SCK  = iQSPI_DCLK & ~iQSPI_NCS;
      oFLASH_CSn  = iQSPI_NCS;
      oFLASH_DOUT = iQSPI_DOUT;
      oFLASH_DOE  = iQSPI_DOE & {4{~iQSPI_NCS}};
    end
  end

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Directed-vector bench for flash_bus_arbiter (GUARD_CYCLES=4, HOLD_TIMEOUT=8).
module tb_flash_bus_arbiter;
  import flash_arb_pkg::*;

  logic       iCLK = 1'b0;
  logic       iRESETn;
  logic       iSPI_REQ, iSPI_SCK, iSPI_MOSI, iSPI_CSn;
  logic       iQSPI_REQ, iQSPI_DCLK, iQSPI_NCS;
  logic [3:0] iQSPI_DOUT, iQSPI_DOE, iFLASH_DIN;
  logic       oSPI_GNT, oSPI_MISO, oQSPI_GNT;
  logic [3:0] oQSPI_DIN, oFLASH_DOUT, oFLASH_DOE;
  logic       oFLASH_SCK, oFLASH_CSn, oPREEMPT, oPROTO_ERR;

  int n_tests = 0;
  int n_fail  = 0;

  flash_bus_arbiter #(.GUARD_CYCLES(4), .HOLD_TIMEOUT(8), .CNT_W(16)) dut (
    .iCLK(iCLK), .iRESETn(iRESETn),
    .iSPI_REQ(iSPI_REQ), .oSPI_GNT(oSPI_GNT), .iSPI_SCK(iSPI_SCK),
    .iSPI_MOSI(iSPI_MOSI), .iSPI_CSn(iSPI_CSn), .oSPI_MISO(oSPI_MISO),
    .iQSPI_REQ(iQSPI_REQ), .oQSPI_GNT(oQSPI_GNT), .iQSPI_DCLK(iQSPI_DCLK),
    .iQSPI_NCS(iQSPI_NCS), .iQSPI_DOUT(iQSPI_DOUT), .iQSPI_DOE(iQSPI_DOE),
    .oQSPI_DIN(oQSPI_DIN), .oFLASH_SCK(oFLASH_SCK), .oFLASH_CSn(oFLASH_CSn),
    .oFLASH_DOUT(oFLASH_DOUT), .oFLASH_DOE(oFLASH_DOE), .iFLASH_DIN(iFLASH_DIN),
    .oPREEMPT(oPREEMPT), .oPROTO_ERR(oPROTO_ERR)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled mid-cycle.
  task automatic cyc();
    @(posedge iCLK);
    #1;
  endtask

  task automatic pads_idle(input string tag);
    check({tag, ".csn"}, 32'(oFLASH_CSn), 32'd1);
    check({tag, ".sck"}, 32'(oFLASH_SCK), 32'd0);
    check({tag, ".doe"}, 32'(oFLASH_DOE), 32'd0);
    check({tag, ".dout"}, 32'(oFLASH_DOUT), 32'd0);
    check({tag, ".gnt"}, {30'd0, oSPI_GNT, oQSPI_GNT}, 32'd0);
  endtask

  logic saw_preempt;
  int   waited;

  initial begin
    iRESETn = 1'b0;
    iSPI_REQ = 1'b0; iSPI_SCK = 1'b0; iSPI_MOSI = 1'b0; iSPI_CSn = 1'b1;
    iQSPI_REQ = 1'b0; iQSPI_DCLK = 1'b0; iQSPI_NCS = 1'b1;
    iQSPI_DOUT = 4'h0; iQSPI_DOE = 4'h0; iFLASH_DIN = 4'h0;

    // Reset, then the power-on guard with no requests.
    repeat (2) cyc();
    pads_idle("rst");
    check("rst.state", 32'(dut.r_state), 32'(GUARD));
    iRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      pads_idle("pwr_guard");
      check("pwr_guard.state", 32'(dut.r_state), 32'(GUARD));
    end
    cyc();
    check("pwr_idle.state", 32'(dut.r_state), 32'(IDLE));
    pads_idle("pwr_idle");

    // Single SPI request: grant on the following cycle, pads follow SPI pins.
    iSPI_REQ = 1'b1;
    #1;
    check("spi_req.gnt_same_cycle", 32'(oSPI_GNT), 32'd0);
    cyc();
    check("spi.gnt", {30'd0, oSPI_GNT, oQSPI_GNT}, 32'b10);
    iSPI_MOSI = 1'b1; iSPI_CSn = 1'b0; iSPI_SCK = 1'b1; iFLASH_DIN = 4'b0010;
    #1;
    check("spi.dout", 32'(oFLASH_DOUT), 32'b1101);
    check("spi.doe", 32'(oFLASH_DOE), 32'b1101);
    check("spi.csn", 32'(oFLASH_CSn), 32'd0);
    check("spi.sck", 32'(oFLASH_SCK), 32'd1);
    check("spi.miso", 32'(oSPI_MISO), 32'd1);
    check("spi.qspi_din", 32'(oQSPI_DIN), 32'b0010);
    iSPI_CSn = 1'b1; iSPI_REQ = 1'b0; iSPI_MOSI = 1'b0; iSPI_SCK = 1'b0;
    #1;
    check("spi_rel.proto", 32'(oPROTO_ERR), 32'd0);
    cyc();
    pads_idle("spi_rel");

    // Reset again; both requests raised during the guard: SPI wins in IDLE.
    iRESETn = 1'b0;
    cyc();
    iRESETn = 1'b1;
    iSPI_REQ = 1'b1; iQSPI_REQ = 1'b1; iSPI_CSn = 1'b0;
    iQSPI_NCS = 1'b0; iQSPI_DOE = 4'b1010; iQSPI_DOUT = 4'b0110; iQSPI_DCLK = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      pads_idle("both_guard");
    end
    cyc();
    pads_idle("both_idle");
    cyc();
    check("both.gnt", {30'd0, oSPI_GNT, oQSPI_GNT}, 32'b10);
    check("both.csn", 32'(oFLASH_CSn), 32'd0);

    // SPI releases cleanly; 4 guard cycles, one idle cycle, then QSPI.
    iSPI_CSn = 1'b1; iSPI_REQ = 1'b0;
    #1;
    check("rr_rel.preempt", 32'(oPREEMPT), 32'd0);
    check("rr_rel.proto", 32'(oPROTO_ERR), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      pads_idle("rr_guard");
      check("rr_guard.state", 32'(dut.r_state), 32'(GUARD));
    end
    cyc();
    pads_idle("rr_idle");
    cyc();
    check("rr.qspi_gnt", {30'd0, oSPI_GNT, oQSPI_GNT}, 32'b01);
    check("rr.qspi_csn", 32'(oFLASH_CSn), 32'd0);
    check("rr.qspi_doe", 32'(oFLASH_DOE), 32'b1010);
    check("rr.qspi_dout", 32'(oFLASH_DOUT), 32'b0110);
    check("rr.qspi_sck", 32'(oFLASH_SCK), 32'd1);
    iQSPI_NCS = 1'b1;
    #1;
    check("rr.ncs_hi_doe", 32'(oFLASH_DOE), 32'b0000);
    check("rr.ncs_hi_sck", 32'(oFLASH_SCK), 32'd0);
    check("rr.ncs_hi_csn", 32'(oFLASH_CSn), 32'd1);

    // Preemption: QSPI idles with NCS high while SPI waits; pulse on 8th cycle.
    cyc();
    iSPI_REQ = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      #1;
      check("hold.no_preempt", 32'(oPREEMPT), 32'd0);
      cyc();
    end
    #1;
    check("hold.preempt_8th", 32'(oPREEMPT), 32'd1);
    check("hold.still_gnt", 32'(oQSPI_GNT), 32'd1);
    cyc();
    check("preempt.pulse_once", 32'(oPREEMPT), 32'd0);
    check("preempt.state", 32'(dut.r_state), 32'(GUARD));
    pads_idle("preempt_guard");
    repeat (4) cyc();
    cyc();
    check("preempt.spi_wins", {30'd0, oSPI_GNT, oQSPI_GNT}, 32'b10);

    // SPI leaves; QSPI owns with NCS low while SPI waits: never preempted.
    iSPI_REQ = 1'b0; iQSPI_NCS = 1'b0;
    repeat (6) cyc();
    check("ncs_lo.gnt", {30'd0, oSPI_GNT, oQSPI_GNT}, 32'b01);
    iSPI_REQ = 1'b1;
    saw_preempt = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      saw_preempt = saw_preempt | oPREEMPT;
      cyc();
    end
    check("ncs_lo.no_preempt", 32'(saw_preempt), 32'd0);
    check("ncs_lo.hold_cnt", 32'(dut.r_hold_cnt), 32'd0);
    check("ncs_lo.still_gnt", 32'(oQSPI_GNT), 32'd1);

    // QSPI drops REQ mid-transfer: protocol error pulse, pads idle next cycle.
    iSPI_REQ = 1'b0; iQSPI_REQ = 1'b0;
    #1;
    check("proto.pulse", 32'(oPROTO_ERR), 32'd1);
    check("proto.csn_same", 32'(oFLASH_CSn), 32'd0);
    cyc();
    check("proto.pulse_once", 32'(oPROTO_ERR), 32'd0);
    pads_idle("proto_next");

    // Reset in the middle of an SPI grant.
    iSPI_REQ = 1'b1; iSPI_CSn = 1'b0;
    waited = 0;
    while (!oSPI_GNT && waited < 12) begin
      cyc();
      waited++;
    end
    check("mid_rst.got_gnt", 32'(oSPI_GNT), 32'd1);
    check("mid_rst.latency", 32'(waited), 32'd5);
    check("mid_rst.csn_before", 32'(oFLASH_CSn), 32'd0);
    iRESETn = 1'b0;
    cyc();
    pads_idle("mid_rst");
    check("mid_rst.state", 32'(dut.r_state), 32'(GUARD));
    iRESETn = 1'b1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
